// File: rtl/ula_arbiter_ctrl.sv
// Round-robin controller sharing one combinational ULA between two requesters.
// A granted operation is held on the ULA for HOLD_CYCLES clocks. F is then captured
// and returned to the winning requester over a valid/ready response.
module ula_arbiter_ctrl #(
    parameter int unsigned W           = 3,
    parameter int unsigned SW          = 3,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic [SW-1:0] req0_s,
    output logic          resp0_valid,
    input  logic          resp0_ready,
    output logic [W:0]    resp0_f,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    input  logic [SW-1:0] req1_s,
    output logic          resp1_valid,
    input  logic          resp1_ready,
    output logic [W:0]    resp1_f,
    output logic [W-1:0]  ula_a,
    output logic [W-1:0]  ula_b,
    output logic [SW-1:0] ula_s,
    input  logic [W:0]    ula_f,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    // Counter wide enough to hold HOLD_CYCLES. Keep it at least 1 bit wide.
    localparam int unsigned CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    state_t        state;
    logic          last_grant;
    logic          owner;
    logic [CW-1:0] hold_cnt;
    logic [W:0]    result;

    // Grant logic: a single valid requester wins outright; on a tie, the requester
    // that was not granted last time wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == StIdle) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    // Response outputs are decoded from registered state only.
    always_comb begin
        resp0_valid = (state == StResp) && !owner;
        resp1_valid = (state == StResp) && owner;
        resp0_f     = result;
        resp1_f     = result;
        busy        = (state != StIdle);
    end

    // Main FSM: accept, hold the operands on the ULA, capture F, then hand it back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            hold_cnt   <= '0;
            result     <= '0;
            ula_a      <= '0;
            ula_b      <= '0;
            ula_s      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req0_valid && req0_ready) begin
                        ula_a      <= req0_a;
                        ula_b      <= req0_b;
                        ula_s      <= req0_s;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                        hold_cnt   <= CW'(HOLD_CYCLES);
                        state      <= StExec;
                    end else if (req1_valid && req1_ready) begin
                        ula_a      <= req1_a;
                        ula_b      <= req1_b;
                        ula_s      <= req1_s;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                        hold_cnt   <= CW'(HOLD_CYCLES);
                        state      <= StExec;
                    end
                end
                StExec: begin
                    if (hold_cnt == CW'(1)) begin
                        result   <= ula_f;
                        hold_cnt <= '0;
                        state    <= StResp;
                    end else begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end
                end
                StResp: begin
                    if (owner ? resp1_ready : resp0_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbiter_ctrl.sv
// Bench for ula_arbiter_ctrl: directed scenarios plus randomized transactions checked
// against a transaction-level round-robin model. A second instance covers HOLD_CYCLES=3.
module tb_ula_arbiter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // HOLD_CYCLES = 1 instance
    logic       rst;
    logic       req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic       req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [2:0] req0_a, req0_b, req0_s, req1_a, req1_b, req1_s;
    logic [3:0] resp0_f, resp1_f, ula_f;
    logic [2:0] ula_a, ula_b, ula_s;
    logic       busy;

    assign ula_f = {1'b0, ula_a} + {1'b0, ula_b};

    ula_arbiter_ctrl #(.W(3), .SW(3), .HOLD_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_f(resp0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_f(resp1_f),
        .ula_a(ula_a), .ula_b(ula_b), .ula_s(ula_s), .ula_f(ula_f),
        .busy(busy)
    );

    // HOLD_CYCLES = 3 instance
    logic       h_rst;
    logic       h_req0_valid, h_req0_ready, h_resp0_valid, h_resp0_ready;
    logic       h_req1_valid, h_req1_ready, h_resp1_valid, h_resp1_ready;
    logic [2:0] h_req0_a, h_req0_b, h_req0_s, h_req1_a, h_req1_b, h_req1_s;
    logic [3:0] h_resp0_f, h_resp1_f, h_ula_f;
    logic [2:0] h_ula_a, h_ula_b, h_ula_s;
    logic       h_busy;

    assign h_ula_f = {1'b0, h_ula_a} + {1'b0, h_ula_b};

    ula_arbiter_ctrl #(.W(3), .SW(3), .HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst(h_rst),
        .req0_valid(h_req0_valid), .req0_ready(h_req0_ready),
        .req0_a(h_req0_a), .req0_b(h_req0_b), .req0_s(h_req0_s),
        .resp0_valid(h_resp0_valid), .resp0_ready(h_resp0_ready), .resp0_f(h_resp0_f),
        .req1_valid(h_req1_valid), .req1_ready(h_req1_ready),
        .req1_a(h_req1_a), .req1_b(h_req1_b), .req1_s(h_req1_s),
        .resp1_valid(h_resp1_valid), .resp1_ready(h_resp1_ready), .resp1_f(h_resp1_f),
        .ula_a(h_ula_a), .ula_b(h_ula_b), .ula_s(h_ula_s), .ula_f(h_ula_f),
        .busy(h_busy)
    );

    // Model state: who was granted last (1 after reset so requester 0 wins a tie).
    int lg_m;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the HOLD_CYCLES=1 instance. bp = response stall cycles.
    task automatic do_txn(input bit v0, input bit v1,
                          input logic [2:0] a0, input logic [2:0] b0, input logic [2:0] s0,
                          input logic [2:0] a1, input logic [2:0] b1, input logic [2:0] s1,
                          input int bp, output int win);
        logic [2:0] ea, eb, es;
        logic [3:0] ef;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_s = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_s = s1;
        #1;
        if (v0 && v1) win = (lg_m == 0) ? 1 : 0;
        else          win = v1 ? 1 : 0;
        chk("grant_rdy0", 8'(req0_ready), 8'(win == 0));
        chk("grant_rdy1", 8'(req1_ready), 8'(win == 1));
        tick();
        lg_m = win;
        ea = (win == 1) ? a1 : a0;
        eb = (win == 1) ? b1 : b0;
        es = (win == 1) ? s1 : s0;
        ef = {1'b0, ea} + {1'b0, eb};
        chk("exec_ula_a", 8'(ula_a), 8'(ea));
        chk("exec_ula_b", 8'(ula_b), 8'(eb));
        chk("exec_ula_s", 8'(ula_s), 8'(es));
        chk("exec_busy", 8'(busy), 8'd1);
        chk("exec_rdy", 8'({req0_ready, req1_ready}), 8'd0);
        chk("exec_resp", 8'({resp0_valid, resp1_valid}), 8'd0);
        if (win == 1) req1_valid = 1'b0;
        else          req0_valid = 1'b0;
        tick();
        for (int i = 0; i <= bp; i++) begin
            if (i == bp) begin
                if (win == 1) resp1_ready = 1'b1;
                else          resp0_ready = 1'b1;
            end
            chk("resp_valid", 8'({resp0_valid, resp1_valid}), (win == 1) ? 8'd1 : 8'd2);
            chk("resp_f", 8'((win == 1) ? resp1_f : resp0_f), 8'(ef));
            chk("resp_busy", 8'(busy), 8'd1);
            chk("resp_rdy", 8'({req0_ready, req1_ready}), 8'd0);
            tick();
        end
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        chk("done_busy", 8'(busy), 8'd0);
        chk("done_resp", 8'({resp0_valid, resp1_valid}), 8'd0);
    endtask

    initial begin
        int         win;
        bit         pend[2];
        logic [2:0] pa[2], pb[2], ps[2];

        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_s = 0; resp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_s = 0; resp1_ready = 0;
        h_rst = 1'b1;
        h_req0_valid = 0; h_req0_a = 0; h_req0_b = 0; h_req0_s = 0; h_resp0_ready = 0;
        h_req1_valid = 0; h_req1_a = 0; h_req1_b = 0; h_req1_s = 0; h_resp1_ready = 0;
        lg_m = 1;
        tick();
        tick();
        rst = 1'b0;
        h_rst = 1'b0;

        // Reset state: everything reads 0
        chk("rst_ula", 8'({ula_a, ula_b}), 8'd0);
        chk("rst_ula_s", 8'(ula_s), 8'd0);
        chk("rst_f", 8'({resp0_f, resp1_f}), 8'd0);
        chk("rst_resp", 8'({resp0_valid, resp1_valid}), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_rdy", 8'({req0_ready, req1_ready}), 8'd0);

        // 1. Single request 5+1
        do_txn(1, 0, 3'd5, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 0, win);
        chk("t1_f_hold", 8'(resp0_f), 8'h6);

        // 2/3. Ties: requester 1 is next after requester 0 -> 7+7
        do_txn(1, 1, 3'd2, 3'd2, 3'd1, 3'd7, 3'd7, 3'd2, 0, win);
        chk("t2_win", 8'(win), 8'd1);
        chk("t2_f", 8'(resp1_f), 8'hE);
        for (int k = 0; k < 4; k++) begin
            do_txn(1, 1, 3'(k), 3'd1, 3'd3, 3'(k + 2), 3'd4, 3'd5, 0, win);
            chk("t3_order", 8'(win), 8'(k % 2));
        end
        req0_valid = 0; req1_valid = 0;

        // 4. Backpressure for 5 cycles while requester 1 waits
        do_txn(1, 1, 3'd6, 3'd3, 3'd4, 3'd1, 3'd1, 3'd1, 5, win);
        chk("t4_win", 8'(win), 8'd0);
        do_txn(0, 1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 1, win);

        // 6. Reset during EXEC aborts, grant pointer returns to requester 0
        req0_valid = 1; req0_a = 3'd4; req0_b = 3'd4; req0_s = 3'd2;
        tick();
        chk("t6_exec_busy", 8'(busy), 8'd1);
        req0_valid = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lg_m = 1;
        chk("t6_busy", 8'(busy), 8'd0);
        chk("t6_resp", 8'({resp0_valid, resp1_valid}), 8'd0);
        chk("t6_ula", 8'({ula_a, ula_b}), 8'd0);
        chk("t6_f", 8'(resp0_f), 8'd0);
        tick();
        chk("t6_noresp", 8'({resp0_valid, resp1_valid}), 8'd0);
        do_txn(1, 1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 0, win);
        chk("t6_tie", 8'(win), 8'd0);
        req0_valid = 0; req1_valid = 0;

        // 5. HOLD_CYCLES=3: accept 2+3, capture three edges later
        h_req0_valid = 1; h_req0_a = 3'd2; h_req0_b = 3'd3; h_req0_s = 3'd1;
        #1;
        chk("h_rdy0", 8'(h_req0_ready), 8'd1);
        tick();
        chk("h_ula_a", 8'(h_ula_a), 8'd2);
        chk("h_ula_b", 8'(h_ula_b), 8'd3);
        h_req0_valid = 0;
        h_req0_s = 3'd5;
        tick();
        chk("h_t1_resp", 8'(h_resp0_valid), 8'd0);
        chk("h_t1_s", 8'(h_ula_s), 8'd1);
        tick();
        chk("h_t2_resp", 8'(h_resp0_valid), 8'd0);
        chk("h_t2_busy", 8'(h_busy), 8'd1);
        tick();
        chk("h_t3_resp", 8'({h_resp0_valid, h_resp1_valid}), 8'd2);
        chk("h_t3_f", 8'(h_resp0_f), 8'h5);
        chk("h_t3_s", 8'(h_ula_s), 8'd1);
        h_resp0_ready = 1;
        tick();
        h_resp0_ready = 0;
        chk("h_done", 8'(h_busy), 8'd0);

        // Randomized transactions against the round-robin model
        pend[0] = 0; pend[1] = 0;
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    pend[r] = 1;
                    pa[r] = 3'($urandom);
                    pb[r] = 3'($urandom);
                    ps[r] = 3'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                chk("rnd_idle", 8'({busy, req0_ready, req1_ready}), 8'd0);
                tick();
            end else begin
                do_txn(pend[0], pend[1], pa[0], pb[0], ps[0], pa[1], pb[1], ps[1],
                       int'($urandom_range(0, 3)), win);
                pend[win] = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
